// File: rtl/inst_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// inst_encoder_loader_if
// Descriptor channel into the instruction encoder/loader.
//   op_valid / op_ready : handshake, transfer when both high
//   op_kind             : instruction class (R, I-ALU, LW, SW, B, LUI, JAL, JALR)
//   alu_fn              : ALU function for R / I-ALU
//   br_cond             : branch condition for B
//   rd, rs1, rs2        : register indices
//   imm                 : signed immediate / byte offset
// master = descriptor producer, slave = loader.
// ---------------------------------------------------------------------------
interface inst_encoder_loader_if;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_kind;
  logic [3:0]  alu_fn;
  logic [1:0]  br_cond;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output op_valid, op_kind, alu_fn, br_cond, rd, rs1, rs2, imm,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_kind, alu_fn, br_cond, rd, rs1, rs2, imm,
    output op_ready
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// ---------------------------------------------------------------------------
// inst_encoder_loader
// Streaming RV32I encoder + instruction memory loader. Each accepted
// descriptor is packed into a 32-bit RV32I word and written one cycle later
// at the next sequential word address, starting from 0 after i_start.
//
// Ports
//   clk, rst       : clock (rising edge), async active-high reset
//   i_start        : pulse, clear pointer/count/err and enter LOAD
//   i_finish       : pulse, end the load (enter DONE)
//   i_op           : descriptor channel (slave modport)
//   o_irom_we      : single-cycle write strobe per legal accepted op
//   o_irom_addr    : word address of the write
//   o_irom_wdata   : encoded instruction
//   o_count        : words written since start
//   o_busy         : in LOAD
//   o_done         : in DONE with no write pending
//   o_err          : sticky illegal-descriptor flag
//
// Build option
//   RANGE_CHECK_EN : when defined, immediates outside the encodable signed
//                    range are illegal (err, no write); otherwise they are
//                    truncated to the field width.
// ---------------------------------------------------------------------------
module inst_encoder_loader #(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_finish,
  inst_encoder_loader_if.slave  i_op,
  output logic                  o_irom_we,
  output logic [ADDR_W-1:0]     o_irom_addr,
  output logic [31:0]           o_irom_wdata,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

`ifdef RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST  = {1'b0, {ADDR_W{1'b1}}};

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic logic in_rng(logic [31:0] v, int lo, int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

  function automatic enc_t encode(
    logic [3:0]  kind,
    logic [3:0]  fn,
    logic [1:0]  cond,
    logic [4:0]  rd,
    logic [4:0]  rs1,
    logic [4:0]  rs2,
    logic [31:0] imm
  );
    enc_t       e;
    logic [2:0] f3a;
    logic [6:0] f7a;
    logic [2:0] f3b;
    logic       shft;
    e.legal = 1'b1;
    e.word  = '0;
    case (fn[2:0])
      3'd0:    f3a = 3'b111;
      3'd1:    f3a = 3'b110;
      3'd2:    f3a = 3'b100;
      3'd3:    f3a = 3'b001;
      3'd4:    f3a = 3'b101;
      3'd5:    f3a = 3'b101;
      default: f3a = 3'b000;
    endcase
    // sub and sra share the alternate funct7
    f7a  = ((fn[2:0] == 3'd5) || (fn[2:0] == 3'd7)) ? 7'b0100000 : 7'b0000000;
    shft = (fn[2:0] == 3'd3) || (fn[2:0] == 3'd4) || (fn[2:0] == 3'd5);
    // beq/bne/blt/bge -> 000/001/100/101
    f3b  = {cond[1], 1'b0, cond[0]};
    case (kind)
      4'd0: begin
        e.legal = !fn[3];
        e.word  = {f7a, rs2, rs1, f3a, rd, OP_R};
      end
      4'd1: begin
        e.legal = !fn[3] && (fn[2:0] != 3'd7) &&
                  (!RC || (shft ? (imm[31:5] == '0) : in_rng(imm, -2048, 2047)));
        e.word  = shft ? {f7a, imm[4:0], rs1, f3a, rd, OP_I}
                       : {imm[11:0], rs1, f3a, rd, OP_I};
      end
      4'd2: begin
        e.legal = !RC || in_rng(imm, -2048, 2047);
        e.word  = {imm[11:0], rs1, 3'b010, rd, OP_LW};
      end
      4'd3: begin
        e.legal = !RC || in_rng(imm, -2048, 2047);
        e.word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
      end
      4'd4: begin
        e.legal = !RC || in_rng(imm, -4096, 4094);
        e.word  = {imm[12], imm[10:5], rs2, rs1, f3b, imm[4:1], imm[11], OP_B};
      end
      4'd5: begin
        e.word  = {imm[31:12], rd, OP_LUI};
      end
      4'd6: begin
        e.legal = !RC || in_rng(imm, -(1 << 20), (1 << 20) - 2);
        e.word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      4'd7: begin
        e.legal = !RC || in_rng(imm, -2048, 2047);
        e.word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

  state_t              r_state, w_state_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_err;

  enc_t                w_enc;
  logic                w_ready;
  logic                w_acc;
  logic                w_wr;
  logic                w_ill;

  assign w_enc = encode(i_op.op_kind, i_op.alu_fn, i_op.br_cond,
                        i_op.rd, i_op.rs1, i_op.rs2, i_op.imm);
  assign w_acc = i_op.op_valid & w_ready;
  assign w_wr  = w_acc & w_enc.legal;
  assign w_ill = w_acc & ~w_enc.legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    // start blocks acceptance so a restart never mixes in an old-stream op
    w_ready     = (r_state == S_LOAD) && (r_count < DEPTH) && !i_start;
    o_busy      = (r_state == S_LOAD);
    o_done      = (r_state == S_DONE) && !r_we;
    if (i_start) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        // leave LOAD on finish or when this write fills the last word;
        // the write itself still lands next cycle
        S_LOAD: if (i_finish || (w_wr && (r_count == LAST))) w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_wr;
      if (i_start) begin
        r_addr  <= '0;
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_wr) begin
          r_addr  <= r_count[ADDR_W-1:0];
          r_wdata <= w_enc.word;
          r_count <= r_count + 1'b1;
        end
        if (w_ill) r_err <= 1'b1;
      end
    end
  end

  assign i_op.op_ready = w_ready;
  assign o_irom_we     = r_we;
  assign o_irom_addr   = r_addr;
  assign o_irom_wdata  = r_wdata;
  assign o_count       = r_count;
  assign o_err         = r_err;

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Streaming RV32I instruction encoder and instruction-memory loader, the inverse of the core's control decoder. It accepts one instruction description per valid/ready handshake (kind, ALU function, branch condition, register indices, immediate). It packs each description into a 32-bit RV32I word and writes it sequentially into instruction ROM/RAM from word 0. The test infrastructure uses it to build programs for the single-cycle core without an external assembler.

Parameters:
ADDR_W, 10, instruction memory word-address width; capacity DEPTH = 2^ADDR_W words

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: clear pointer/count/err, enter LOAD
finish  in  1  one-cycle pulse: end load, enter DONE
op_valid  in  1  descriptor valid
op_ready  out  1  descriptor accepted when op_valid & op_ready
op_kind  in  4  0 R, 1 I-ALU, 2 LW, 3 SW, 4 B, 5 LUI, 6 JAL, 7 JALR, 8-15 illegal
alu_fn  in  4  0000 and, 0001 or, 0010 xor, 0011 sll, 0100 srl, 0101 sra, 0110 add, 0111 sub
br_cond  in  2  00 beq, 01 bne, 10 blt, 11 bge
rd, rs1, rs2  in  5 each  register indices
imm  in  32  signed immediate / byte offset (LUI: full 32-bit value, low 12 bits ignored)
irom_we  out  1  write strobe
irom_addr  out  ADDR_W  word address
irom_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words written since start
busy  out  1  state == LOAD
done  out  1  state == DONE and no write pending
err  out  1  sticky illegal-descriptor flag

Behaviour:
- Reset (async, any state): state IDLE; irom_we=0, irom_addr=0, irom_wdata=0, count=0, err=0, op_ready=0, busy=0, done=0. Any pending write is dropped.
- FSM IDLE -> LOAD on start. LOAD -> DONE on finish, or automatically once count reaches DEPTH. DONE -> LOAD on start. start from any state restarts: pointer=0, count=0, err=0.
- op_ready = (state==LOAD) & (count<DEPTH) & !start. start wins over a same-cycle op_valid, which is not accepted.
- finish together with an accepted op: the op is written, then the block is in DONE.
- Latency: descriptor accepted in cycle N -> irom_we=1 in cycle N+1, with irom_addr = count before acceptance and the encoded word. count increments in N+1. irom_we is a single-cycle pulse per accepted legal op. Back-to-back acceptance gives one write per cycle.
- A write pending when finish or the full condition hits still completes. done rises the cycle after the last write.
- Encoding rules:
  - R: opcode 0110011. funct3 per alu_fn: and 111, or 110, xor 100, sll 001, srl/sra 101, add/sub 000. funct7 0100000 for sub/sra, else 0.
  - I-ALU: opcode 0010011. alu_fn sub is illegal. sll/srl/sra encode shamt=imm[4:0], with funct7 as for R.
  - LW: opcode 0000011, funct3 010.
  - SW: opcode 0100011, funct3 010, S-format immediate split.
  - B: opcode 1100011, funct3 000/001/100/101 from br_cond, B-format; imm[0] ignored.
  - LUI: opcode 0110111, imm[31:12].
  - JAL: opcode 1101111, J-format; imm[0] ignored.
  - JALR: opcode 1100111, funct3 000.
  - Unused fields (rs2 for I-type, rd for S/B, etc.) are forced to 0.
- Illegal descriptor (kind 8-15, I-ALU sub, alu_fn >0111 for R/I): accepted (handshake completes), no write, count unchanged, err set.

Optional Feature:
RANGE_CHECK_EN.
- Defined: an immediate outside the encodable signed range is treated as illegal (err set, no write). Ranges: I/S/JALR [-2048,2047]; B [-4096,4094]; J [-2^20,2^20-2]; shift imm[31:5] must be 0.
- Undefined: the immediate is silently truncated to the field width and written.

Test Plan:
- start; R add rd=3 rs1=1 rs2=2 -> irom_we next cycle, addr 0, wdata 0x002081B3, count=1.
- R sub rd=5 rs1=6 rs2=7, then LUI rd=1 imm=0x12345000, back-to-back -> addr 0/1, wdata 0x407302B3 then 0x123450B7, no idle cycle.
- B beq rs1=1 rs2=2 imm=-8; JAL rd=1 imm=0x800 -> 0xFE208CE3, 0x001000EF.
- I-ALU add rd=1 imm=2048 -> with RANGE_CHECK_EN: err=1, no write, count unchanged; without: wdata 0x80000093.
- ADDR_W=2, start, present 5 valid ops -> writes at addr 0..3, op_ready low after 4th accept, done=1 after 4th write, 5th op never accepted.
- Mid-stream: rst asserted while a write is pending -> irom_we=0 immediately, all outputs reset. Later start with op_valid high same cycle -> op not accepted that cycle, count=0, err cleared.
